// File: rtl/io_out_arbiter.sv
// io_out_arbiter: round-robin owner of the shared user pad bank.
// Optional stall watchdog enabled by defining IO_ARB_WATCHDOG_EN.
module io_out_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 10,
  parameter int MAX_BURST   = 8,
  parameter int WDOG_CYCLES = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [NREQ-1:0]   req_i,
  input  logic [NREQ-1:0]   valid_i,
  input  logic [NREQ-1:0]   last_i,
  input  logic [NREQ*W-1:0] data_i,
  output logic [NREQ-1:0]   ready_o,
  output logic [NREQ-1:0]   gnt_o,
  output logic              busy_o,
  output logic [W-1:0]      io_out_o,
  output logic [W-1:0]      io_oeb_o,
  output logic              wdog_o
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE, TURN, OWN, HOLD
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   own;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_inc;
  logic [PW-1:0]   win;
  logic [PW-1:0]   win_nxt;
  logic            any;
  logic            beat;
  logic            done;
  logic            wd_hit;
  logic [W-1:0]    dsel;
  logic [PW-1:0]   idx;
  int              s;

  // Round-robin search: first requester at or after ptr, wrapping.
  always_comb begin
    win = '0;
    any = 1'b0;
    idx = '0;
    s   = 0;
    for (int i = 0; i < NREQ; i++) begin
      s = int'(ptr) + i;
      if (s >= NREQ) s = s - NREQ;
      idx = s[PW-1:0];
      if (!any && req_i[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
    win_nxt = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
  end

  // Owner's data slice selection.
  always_comb begin
    dsel = '0;
    for (int k = 0; k < NREQ; k++)
      if (own == PW'(k)) dsel = data_i[k*W +: W];
  end

  assign ready_o = (state == OWN) ? gnt_o : '0;
  assign beat    = (state == OWN) && valid_i[own];
  assign cnt_inc = cnt + 1'b1;
  assign done    = (beat && (last_i[own] || cnt_inc == MAXC))
                 || !req_i[own] || wd_hit;

`ifdef IO_ARB_WATCHDOG_EN
  localparam int SW = $clog2(WDOG_CYCLES + 1);
  localparam logic [SW-1:0] WDC = SW'(WDOG_CYCLES);
  logic [SW-1:0] stall;

  assign wd_hit = (state == OWN) && !beat
                && (stall + 1'b1 == WDC);

  // Count consecutive beatless owner cycles; flag is sticky.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stall  <= '0;
      wdog_o <= 1'b0;
    end else if (state != OWN || beat) begin
      stall <= '0;
    end else if (wd_hit) begin
      stall  <= '0;
      wdog_o <= 1'b1;
    end else begin
      stall <= stall + 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign wdog_o = 1'b0;
`endif

  // Grant sequencer with registered pad and grant outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      ptr      <= '0;
      own      <= '0;
      cnt      <= '0;
      gnt_o    <= '0;
      busy_o   <= 1'b0;
      io_out_o <= '0;
      io_oeb_o <= '1;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          io_oeb_o <= '1;
          if (any) begin
            state  <= TURN;
            own    <= win;
            ptr    <= win_nxt;
            gnt_o  <= NREQ'(1) << win;
            busy_o <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        TURN: begin
          state    <= OWN;
          cnt      <= '0;
          io_oeb_o <= '0;
        end
        OWN: begin
          if (beat) begin
            io_out_o <= dsel;
            cnt      <= cnt_inc;
          end
          if (done) begin
            state <= HOLD;
            gnt_o <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_out_arbiter.sv
// tb_io_out_arbiter: random and directed checks of io_out_arbiter
// against a transaction-level reference model.
module tb_io_out_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 10;
  localparam int MAXB = 8;
  localparam int WDOG = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   valid = '0;
  logic [NREQ-1:0]   last = '0;
  logic [NREQ*W-1:0] data = '0;
  logic [NREQ-1:0]   ready;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [W-1:0]      io_out;
  logic [W-1:0]      io_oeb;
  logic              wdog;

  io_out_arbiter #(
    .NREQ(NREQ), .W(W), .MAX_BURST(MAXB), .WDOG_CYCLES(WDOG)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_i(req), .valid_i(valid), .last_i(last), .data_i(data),
    .ready_o(ready), .gnt_o(gnt), .busy_o(busy),
    .io_out_o(io_out), .io_oeb_o(io_oeb), .wdog_o(wdog)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 turnaround, 2 owned, 3 hold.
  int ph = 0;
  int mptr = 0;
  int mown = 0;
  int mcnt = 0;
  int mstall = 0;
  logic [W-1:0] mout = '0;
  bit mwd = 0;
  int gq[$];
  int bq[$];

  // Directed sources: per-requester beat queues, bit W is last.
  logic [W:0] q[NREQ][$];
  logic [NREQ-1:0] hold = '0;
  logic [NREQ-1:0] kill = '0;
  bit rnd = 0;

  function automatic int pick(logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit fin;
    if (rst) begin
      ph = 0; mptr = 0; mout = '0; mwd = 0;
      return;
    end
    case (ph)
      0, 3: begin
        w = pick(req);
        if (w >= 0) begin
          mown = w; mptr = (w + 1) % NREQ; ph = 1;
          gq.push_back(w);
        end else ph = 0;
      end
      1: begin ph = 2; mcnt = 0; mstall = 0; end
      default: begin
        fin = 0;
        if (valid[mown]) begin
          mout = data[mown*W +: W];
          mcnt++;
          mstall = 0;
          if (q[mown].size() > 0) void'(q[mown].pop_front());
          if (last[mown] || mcnt == MAXB) fin = 1;
        end else begin
          mstall++;
`ifdef IO_ARB_WATCHDOG_EN
          if (mstall == WDOG) begin fin = 1; mwd = 1; end
`endif
        end
        if (!req[mown]) fin = 1;
        if (fin) begin ph = 3; bq.push_back(mcnt); end
      end
    endcase
  endtask

  task automatic compare();
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << mown;
    chk("gnt", gnt, (ph == 1 || ph == 2) ? oh : '0);
    chk("ready", ready, (ph == 2) ? oh : '0);
    chk("busy", busy, ph != 0);
    chk("io_oeb", io_oeb, (ph == 2 || ph == 3) ? 10'h000 : 10'h3FF);
    chk("io_out", io_out, mout);
    chk("wdog", wdog, mwd);
  endtask

  task automatic drive();
    for (int k = 0; k < NREQ; k++) begin
      if (rnd) begin
        req[k] = ($urandom_range(0, 9) < 6);
        valid[k] = ($urandom_range(0, 9) < 7);
        last[k] = ($urandom_range(0, 9) < 2);
        data[k*W +: W] = W'($urandom);
      end else begin
        req[k] = (q[k].size() > 0 || hold[k]) && !kill[k];
        valid[k] = q[k].size() > 0;
        last[k] = valid[k] ? q[k][0][W] : 1'b0;
        data[k*W +: W] = valid[k] ? q[k][0][W-1:0] : '0;
      end
    end
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    for (int k = 0; k < NREQ; k++) q[k].delete();
    hold = '0; kill = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    gq.delete(); bq.delete();
  endtask

  initial begin
    // Reset and idle.
    do_reset();
    chk("rst_oeb", io_oeb, 10'h3FF);
    chk("rst_out", io_out, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    tick();

    // Single burst from requester 1.
    q[1].push_back({1'b0, 10'h155});
    q[1].push_back({1'b0, 10'h2AA});
    q[1].push_back({1'b1, 10'h0F0});
    tick();
    chk("sb_gnt", gnt, 4'b0010);
    chk("sb_turn_oeb", io_oeb, 10'h3FF);
    tick();
    chk("sb_own_oeb", io_oeb, 10'h000);
    tick(); chk("sb_b0", io_out, 10'h155);
    tick(); chk("sb_b1", io_out, 10'h2AA);
    tick(); chk("sb_b2", io_out, 10'h0F0);
    chk("sb_hold_gnt", gnt, 0);
    chk("sb_hold_oeb", io_oeb, 10'h000);
    tick();
    chk("sb_idle_oeb", io_oeb, 10'h3FF);
    chk("sb_idle_out", io_out, 10'h0F0);

    // Round-robin with single-beat bursts.
    do_reset();
    q[0].push_back({1'b1, 10'h001});
    q[0].push_back({1'b1, 10'h005});
    q[1].push_back({1'b1, 10'h002});
    q[2].push_back({1'b1, 10'h003});
    q[3].push_back({1'b1, 10'h004});
    for (int i = 0; i < 30; i++) tick();
    chk("rr_n", gq.size(), 5);
    if (gq.size() == 5) begin
      chk("rr_0", gq[0], 0); chk("rr_1", gq[1], 1);
      chk("rr_2", gq[2], 2); chk("rr_3", gq[3], 3);
      chk("rr_4", gq[4], 0);
    end

    // Burst cap: requester 2 sends 12 beats without last.
    do_reset();
    q[0].push_back({1'b1, 10'h011});
    for (int i = 0; i < 12; i++) q[2].push_back({1'b0, W'(10'h100 + i)});
    q[3].push_back({1'b1, 10'h033});
    for (int i = 0; i < 40; i++) tick();
    chk("cap_ngrants", gq.size(), 4);
    if (gq.size() == 4 && bq.size() == 4) begin
      chk("cap_g1", gq[1], 2); chk("cap_g2", gq[2], 3);
      chk("cap_g3", gq[3], 2);
      chk("cap_beats", bq[1], 8);
      chk("cap_rest", bq[3], 4);
    end
    chk("cap_out", io_out, 10'h10B);

    // Release: owner drops req in a cycle with a valid beat.
    do_reset();
    for (int i = 1; i <= 5; i++) q[1].push_back({1'b0, W'(i * 17)});
    tick(); tick(); tick();
    chk("rel_b0", io_out, 10'd17);
    kill[1] = 1'b1;
    tick();
    chk("rel_b1", io_out, 10'd34);
    chk("rel_gnt", gnt, 0);
    chk("rel_ready", ready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rel_noready", ready, 0);
    end

    // Stalled owner: watchdog behaviour depends on the build.
    do_reset();
    hold[3] = 1'b1;
    tick(); tick();
`ifdef IO_ARB_WATCHDOG_EN
    for (int i = 0; i < WDOG; i++) tick();
    chk("wd_hold_gnt", gnt, 0);
    chk("wd_flag", wdog, 1);
    hold[3] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("wd_sticky", wdog, 1);
`else
    for (int i = 0; i < 100; i++) tick();
    chk("wd_off_gnt", gnt, 4'b1000);
    chk("wd_off_flag", wdog, 0);
    chk("wd_off_oeb", io_oeb, 10'h000);
`endif

    // Random traffic including occasional mid-burst reset.
    do_reset();
    rnd = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    rnd = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_out_arbiter.md
# io_out_arbiter

Round-robin arbiter and sequencer for the shared 10-bit user output pad bank (io_out[37:28] / io_oeb[37:28]) of the user project. Up to NREQ internal requesters compete for the pad bank. The block grants one requester at a time and inserts a one-cycle bus turnaround with all pads tri-stated before each ownership. It then streams the owner's beats onto the pads, holds the last beat for one cycle, and releases. Its outputs connect directly to the wrapper's io_out/io_oeb slice.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 10, pad bank width
- MAX_BURST, 8, maximum beats per grant (1..255)
- WDOG_CYCLES, 16, idle-owner timeout; used only with the watchdog macro
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_i  in  1  reset; synchronous, active-high
- req_i  in  NREQ  per-requester ownership request (level)
- valid_i  in  NREQ  beat valid per requester
- last_i  in  NREQ  final beat of burst; qualified by valid_i and ready_o
- data_i  in  NREQ*W  beat data; requester k uses bits [k*W +: W]
- ready_o  out  NREQ  beat accept; one-hot or zero
- gnt_o  out  NREQ  current owner; registered, one-hot or zero
- busy_o  out  1  high in any state other than IDLE
- io_out_o  out  W  pad data; registered
- io_oeb_o  out  W  pad output enable, active-low; all bits identical
- wdog_o  out  1  sticky watchdog-abort flag; tied 0 without the macro

## Operation
- States: IDLE, TURN, OWN, HOLD. All state and outputs are registered except ready_o.
- IDLE: gnt_o=0, io_oeb_o all 1. If any req_i is high, pick a winner and go to TURN.
- Arbitration: the winner is the lowest index at or above pointer ptr (with wrap) whose req_i is high. On the grant, ptr becomes winner+1 mod NREQ.
- TURN (1 cycle): gnt_o[winner]=1 and io_oeb_o still all 1. Go to OWN and clear the beat counter.
- OWN: io_oeb_o all 0, ready_o[owner]=valid-independent 1, all other bits of ready_o are 0.
  - A beat occurs when valid_i[owner]&ready_o[owner]. On a beat, io_out_o takes the owner's data slice on the next edge and the counter increments.
  - With no beat, io_out_o holds its value.
- The burst ends (OWN→HOLD) on any of:
  - a beat with last_i[owner]=1;
  - a beat that brings the counter to MAX_BURST;
  - req_i[owner]=0, sampled at any OWN cycle. A beat in that same cycle is still accepted.
- HOLD (1 cycle): io_oeb_o stays 0, io_out_o holds the last beat, gnt_o=0, ready_o=0.
  - If any req_i is high, arbitrate and go to TURN.
  - Otherwise go to IDLE, where io_oeb_o returns to all 1.
- Non-owners' valid_i and last_i are ignored.
- A requester keeping req_i high after its burst ends competes again with the rotated pointer, so others win first.
- ptr, the counter and state are width-safe. The counter has ceil(log2(MAX_BURST+1)) bits and never wraps, because the burst ends at MAX_BURST.

## Timing
- Reset values: state IDLE, ptr 0, gnt_o 0, ready_o 0, busy_o 0, io_out_o 0, io_oeb_o all 1, wdog_o 0.
- Reset asserted mid-burst takes effect at the next edge and overrides all other transitions. No HOLD is performed.
- Request latency: req_i seen in IDLE at cycle t gives TURN at t+1 and OWN (first possible beat) at t+2.
- A beat accepted at cycle c appears on io_out_o at c+1.
- Back-to-back owners: OWN(A) last beat at c, HOLD at c+1, TURN(B) at c+2, OWN(B) at c+3.
- Pads are never driven in TURN. io_oeb_o is high for at least one full cycle between owners.
- Minimum grant is 3 cycles (TURN, OWN, HOLD), even when the owner drops req_i in its first OWN cycle.

## Configuration
- IO_ARB_WATCHDOG_EN defined: a stall counter counts consecutive OWN cycles without a beat and clears on each beat.
  - When it reaches WDOG_CYCLES, the burst ends exactly as on last (OWN→HOLD) and wdog_o sets.
  - wdog_o stays set until reset.
- IO_ARB_WATCHDOG_EN undefined: no stall counter. The owner may stall indefinitely while req_i is high, and wdog_o is constant 0.

## Test plan
- Reset/idle: assert wb_rst_i 2 cycles with req_i=0 → io_oeb_o=10'h3FF, io_out_o=0, gnt_o=0, busy_o=0 throughout.
- Single burst:
  - Stimulus: req_i=4'b0010; beats 10'h155, 10'h2AA, 10'h0F0 with last on the third.
  - Required: gnt_o=0010 at t+1. io_oeb_o=0 from t+2. io_out_o shows the three values on consecutive cycles from t+3, holds 0F0 in HOLD, and io_oeb_o=3FF one cycle later.
- Round-robin: req_i=4'b1111 held, each requester sending single-beat last bursts → grant order 0,1,2,3,0. Each HOLD is followed by TURN with io_oeb_o=3FF.
- MAX_BURST cap: requester 2 streams 12 beats with no last → exactly 8 beats accepted. Requester 2 is re-granted only after the other active requesters have had their turns.
- Release: owner drops req_i mid-burst in the same cycle as a valid beat → that beat appears on io_out_o, then HOLD; no further ready_o.
- Watchdog (macro on, WDOG_CYCLES=16): owner holds req_i with valid_i=0 → HOLD entered after 16 stall cycles and wdog_o=1 until reset. With the macro off, the grant is held for 100 cycles and wdog_o=0.
